// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter serialising I-cache fills and D-cache fills/writebacks onto one L2 line port.
// Request fields are latched at grant; each transaction is held on L2 until l2_resp.
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitrate between requesters
// SERVE_I | I-cache read presented to L2, waiting for l2_resp
// SERVE_D | D-cache read/write presented to L2, waiting for l2_resp
module l1_l2_arbiter #(
  parameter int LINE_W = 256,
  parameter int MASK_W = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_wmask,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  output logic [MASK_W-1:0] l2_wmask,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q;
  logic              rr_last_q;  // 1 when the D-cache holds the most recent grant
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              l2_read_q;
  logic              l2_write_q;

  logic i_act, d_act, grant_i, grant_d;

  assign i_act   = i_read;
  assign d_act   = d_read | d_write;
  assign grant_d = d_act & (~i_act | ~rr_last_q);
  assign grant_i = i_act & ~grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            // a simultaneous read+write request is treated as a write
            state_q    <= SERVE_D;
            rr_last_q  <= 1'b1;
            addr_q     <= d_address;
            l2_write_q <= d_write;
            l2_read_q  <= ~d_write;
            wdata_q    <= d_write ? d_wdata : '0;
            wmask_q    <= d_write ? d_wmask : '0;
          end else if (grant_i) begin
            state_q    <= SERVE_I;
            rr_last_q  <= 1'b0;
            addr_q     <= i_address;
            l2_write_q <= 1'b0;
            l2_read_q  <= 1'b1;
            wdata_q    <= '0;
            wmask_q    <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            state_q    <= IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign l2_wmask   = wmask_q;

  assign i_resp  = (state_q == SERVE_I) & l2_resp;
  assign d_resp  = (state_q == SERVE_D) & l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of grant order, latched fields and response timing.
module tb_l1_l2_arbiter;
  localparam int LW = 256;
  localparam int MW = LW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, l2_resp;
  logic [31:0]   i_address, d_address;
  logic [LW-1:0] d_wdata, l2_rdata;
  logic [MW-1:0] d_wmask;
  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [31:0]   l2_address;
  logic [MW-1:0] l2_wmask;

  l1_l2_arbiter #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_wmask(l2_wmask), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // requester intent and knobs
  bit            i_pend, d_pend, i_blk, d_blk;
  bit            rand_req, rand_fields, rdata_fix_en;
  int            lat_fixed;
  logic [31:0]   i_addr_v, d_addr_v;
  logic [LW-1:0] d_wdata_v, rdata_fix;
  logic [MW-1:0] d_wmask_v;
  bit            d_rd_v, d_wr_v;

  // reference model: who owns L2, what was latched, cycles until L2 answers
  int            m_owner;   // 0 none, 1 I, 2 D
  int            m_last;    // 1 I, 2 D
  int            m_cnt;
  bit            m_wr;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  bit            prev_strobe;
  logic [31:0]   obs_addr[$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_cnt = 0; prev_strobe = 0;
    i_blk = 0; d_blk = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; i_pend = 0; d_pend = 0;
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic cycle();
    int op;
    logic [LW-1:0] rd;
    @(negedge clk);
    if (i_blk) i_blk = 0;
    else if (rand_req && !i_pend && $urandom_range(0, 2) == 0) i_pend = 1;
    if (d_blk) d_blk = 0;
    else if (rand_req && !d_pend && $urandom_range(0, 2) == 0) d_pend = 1;
    if (rand_fields) begin
      i_addr_v  = $urandom;
      d_addr_v  = $urandom;
      d_wdata_v = rand_line();
      d_wmask_v = $urandom;
      op        = $urandom_range(0, 2);
      d_rd_v    = (op != 1);
      d_wr_v    = (op != 0);
    end
    i_read    = i_pend;
    i_address = i_addr_v;
    d_read    = d_pend & d_rd_v;
    d_write   = d_pend & d_wr_v;
    d_address = d_addr_v;
    d_wdata   = d_wdata_v;
    d_wmask   = d_wmask_v;
    rd        = rdata_fix_en ? rdata_fix : rand_line();
    l2_rdata  = rd;
    l2_resp   = (m_owner != 0) && (m_cnt == 0);
    #1;
    if ((l2_read || l2_write) && !prev_strobe) obs_addr.push_back(l2_address);
    prev_strobe = l2_read | l2_write;
    if (m_owner != 0) begin
      chk("l2_read", l2_read, !m_wr);
      chk("l2_write", l2_write, m_wr);
      chk("l2_address", l2_address, m_addr);
      chk("l2_wdata", l2_wdata, m_wdata);
      chk("l2_wmask", l2_wmask, m_wmask);
    end else begin
      chk("idle_l2_read", l2_read, 0);
      chk("idle_l2_write", l2_write, 0);
    end
    chk("i_resp", i_resp, (m_owner == 1) && l2_resp);
    chk("d_resp", d_resp, (m_owner == 2) && l2_resp);
    if (i_resp) chk("i_rdata", i_rdata, rd);
    if (d_resp) chk("d_rdata", d_rdata, rd);
    // advance the model across the coming rising edge
    if (m_owner != 0) begin
      if (l2_resp) begin
        if (m_owner == 1) begin i_pend = 0; i_blk = 1; end
        else begin d_pend = 0; d_blk = 1; end
        m_owner = 0;
      end else m_cnt--;
    end else if (i_pend || d_pend) begin
      // round robin: on a tie the requester not granted last time wins
      if (d_pend && (!i_pend || m_last == 1)) begin
        m_owner = 2;
        m_wr    = d_write;
        m_addr  = d_address;
        m_wdata = d_write ? d_wdata : '0;
        m_wmask = d_write ? d_wmask : '0;
      end else begin
        m_owner = 1;
        m_wr    = 0;
        m_addr  = i_address;
        m_wdata = '0;
        m_wmask = '0;
      end
      m_last = m_owner;
      m_cnt  = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      cycle();
      done = (m_owner == 0) && !i_pend && !d_pend;
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    rst = 1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_wmask = 0; l2_rdata = 0;
    i_pend = 0; d_pend = 0; rand_req = 0; rand_fields = 0; rdata_fix_en = 0;
    lat_fixed = 1; rdata_fix = '0;
    i_addr_v = 0; d_addr_v = 0; d_wdata_v = 0; d_wmask_v = 0; d_rd_v = 0; d_wr_v = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l2_address", l2_address, 0);
    chk("rst_l2_wdata", l2_wdata, 0);
    chk("rst_l2_wmask", l2_wmask, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    rst = 0;

    // single I-cache fill, L2 answers on the third serve cycle
    rdata_fix_en = 1; rdata_fix = {32{8'hA5}}; lat_fixed = 2;
    i_addr_v = 32'h0000_0040; i_pend = 1;
    drain();
    rdata_fix_en = 0;

    // D-cache write with a partial mask
    d_addr_v = 32'h1000_0020; d_wdata_v = 256'hDEAD_BEEF; d_wmask_v = 32'h0000_000F;
    d_rd_v = 0; d_wr_v = 1; d_pend = 1; lat_fixed = 1;
    drain();

    // simultaneous requests from reset: D, I, then D again
    do_reset();
    obs_addr.delete();
    i_addr_v = 32'h0000_0100; d_addr_v = 32'h0000_0200; d_rd_v = 1; d_wr_v = 0;
    i_pend = 1; d_pend = 1; lat_fixed = 1;
    drain();
    i_pend = 1; d_pend = 1;
    drain();
    chk("order_len", obs_addr.size(), 4);
    if (obs_addr.size() == 4) begin
      chk("order_0_d", obs_addr[0], 32'h0000_0200);
      chk("order_1_i", obs_addr[1], 32'h0000_0100);
      chk("order_2_d", obs_addr[2], 32'h0000_0200);
      chk("order_3_i", obs_addr[3], 32'h0000_0100);
    end

    // read and write together: write wins, full mask
    d_addr_v = 32'h2000_0000; d_wdata_v = rand_line(); d_wmask_v = 32'hFFFF_FFFF;
    d_rd_v = 1; d_wr_v = 1; d_pend = 1;
    drain();

    // inputs moving during SERVE_D must not reach L2
    d_addr_v = 32'h3000_0040; d_wmask_v = 32'h00FF_00FF; d_wdata_v = rand_line();
    d_rd_v = 0; d_wr_v = 1; d_pend = 1; lat_fixed = 4;
    run(2);
    d_addr_v = 32'hFFFF_FFC0; d_wmask_v = '0; d_wdata_v = '0;
    drain();

    // reset while serving an I fill; a late l2_resp is ignored
    i_addr_v = 32'h0000_0080; i_pend = 1; lat_fixed = 5;
    run(2);
    chk("pre_rst_l2_read", l2_read, 1);
    @(negedge clk);
    rst = 1; i_pend = 0; i_read = 0;
    #1;
    chk("async_rst_l2_read", l2_read, 0);
    chk("async_rst_l2_address", l2_address, 0);
    @(negedge clk);
    rst = 0; l2_resp = 1;
    #1;
    chk("late_resp_i_resp", i_resp, 0);
    chk("late_resp_d_resp", d_resp, 0);
    model_reset();
    i_addr_v = 32'h0000_00C0; i_pend = 1; lat_fixed = 1;
    drain();

    // randomized traffic
    rand_req = 1; rand_fields = 1; lat_fixed = -1;
    run(3000);
    rand_req = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
Two-requester arbiter between the split L1 caches and the shared L2 line port. It serialises I-cache line fills and D-cache line fills/writebacks onto one L2 interface. D-cache writes carry a per-byte write mask, which the arbiter latches and forwards unchanged. Fairness is round-robin; each transaction is held until L2 responds.

Parameters:
LINE_W, 256, cache line width in bits
MASK_W, LINE_W/8, byte-mask width; one bit per line byte

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_read  in  1  I-cache line read request
i_address  in  32  I-cache line address
i_rdata  out  LINE_W  read data to I-cache
i_resp  out  1  I-cache completion pulse
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write request
d_address  in  32  D-cache line address
d_wdata  in  LINE_W  D-cache write data
d_wmask  in  MASK_W  D-cache byte write mask
d_rdata  out  LINE_W  read data to D-cache
d_resp  out  1  D-cache completion pulse
l2_read  out  1  L2 read strobe
l2_write  out  1  L2 write strobe
l2_address  out  32  L2 address
l2_wdata  out  LINE_W  L2 write data
l2_wmask  out  MASK_W  L2 byte write mask
l2_rdata  in  LINE_W  L2 read data
l2_resp  in  1  L2 completion

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. One clock domain.
- Reset values:
  - State: IDLE.
  - rr_last = I, so D-cache has priority on the first tie.
  - All latched address, data, mask and op registers: 0.
  - l2_read, l2_write, i_resp, d_resp: 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Requester active when i_read, or d_read|d_write.
  - None active: stay in IDLE.
  - One active: grant it.
  - Both active: grant the one not equal to rr_last.
  - On grant, latch that requester's address, op, wdata and wmask. Update rr_last to the granted requester. Go to SERVE_x.
  - All L2 strobes are 0 in IDLE.
- D op encoding:
  - d_write=1 latches a write, whether or not d_read is also 1; write wins.
  - d_read alone latches a read.
- I-cache reads latch wdata=0 and wmask=0.
- SERVE_I / SERVE_D:
  - Drive l2_address, l2_wdata and l2_wmask from the latched registers.
  - Drive l2_read or l2_write per the latched op; held constant until l2_resp.
  - Read ops always present l2_wmask=0 and l2_wdata=0.
  - On l2_resp=1: pulse the granted requester's resp combinationally in that same cycle; return to IDLE next edge.
- i_rdata and d_rdata are wired to l2_rdata continuously. Valid only while the matching resp is 1.
- l2_resp in IDLE is ignored; no resp is generated.
- Requesters hold their request until their resp and must drop it the following cycle.
- Latency:
  - Request seen in IDLE at cycle 0 → L2 strobe at cycle 1.
  - L2 response at cycle N → requester resp at cycle N, IDLE at N+1.
  - Next grant is visible on L2 at N+2.
- Input changes during SERVE_x do not affect L2 outputs; inputs are latched only at grant.
- Reset mid-transaction: outputs drop to 0 asynchronously and state returns to IDLE. A late l2_resp is ignored. The aborted requester must re-request.
- Starvation bound: a continuously requesting cache waits at most one foreign transaction.

Test Plan:
- Reset, then i_read=1, i_address=0x0000_0040; L2 responds after 3 cycles with rdata=0xA5..A5. Required:
  - l2_read=1 at cycle 1.
  - i_resp pulses exactly once, with i_rdata=0xA5..A5.
  - l2_write=0 and l2_wmask=0 throughout.
- d_write=1, d_address=0x1000_0020, d_wmask=0x0000_000F, d_wdata=0x…DEADBEEF. Required:
  - l2_write=1 with l2_wmask=0x0000_000F and the same data/address.
  - d_resp pulses on l2_resp.
  - i_resp stays 0.
- i_read and d_read asserted together from reset, both held until served. Required:
  - D served first.
  - I served second; L2 strobe for I at cycle N+2 after D's l2_resp at cycle N.
  - Then the third transaction goes back to D.
- d_read=1 and d_write=1 simultaneously with d_wmask=0xFFFF_FFFF → l2_write=1, l2_read=0.
- During SERVE_D, change d_address to 0xFFFF_FFC0 and d_wmask to 0 → l2_address and l2_wmask keep their granted values until l2_resp.
- Assert rst for 1 cycle while in SERVE_I, then pulse l2_resp. Required:
  - l2_read drops to 0 immediately.
  - No i_resp is generated.
  - The next request is granted from IDLE normally.
